vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Arbitrates the single-port synchronous video RAM between the video scan-out fetch path and the CPU bus. Video fetches have fixed priority and a one-cycle read latency. CPU reads and writes use a request/acknowledge handshake and are served in idle video slots. An optional starvation guard forces a CPU slot when the CPU has waited too long, and flags the video side when it does.

## Interface
- `RAM_SIZE`, 8192: RAM depth in bytes.
- `ADDR_WIDTH`, `$clog2(RAM_SIZE)`: address width.
- `XLEN`, 8: data width.
- `STARVE_LIMIT`, 16: CPU wait cycles before a forced CPU slot (guard builds only); legal range 1–255.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `vid_req`  in  1  video wants a read this cycle.
- `vid_addr`  in  ADDR_WIDTH  video read address.
- `vid_rdata`  out  XLEN  video read data, one cycle after the request.
- `vid_miss`  out  1  pulse: this cycle's `vid_rdata` is stale because the slot was stolen.
- `cpu_req`  in  1  level; held with `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  CPU address.
- `cpu_wdata`  in  XLEN  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  XLEN  registered read data; valid with `cpu_ack`, held until the next read ack.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  XLEN  RAM write data.
- `ram_rdata`  in  XLEN  RAM read data, one cycle after the address.

## Operation
- **FSM states:** IDLE, WAIT_DATA, ACK.
- **IDLE:** the CPU wins the RAM port when `cpu_req && (!vid_req || force)`.
  - On a win, drive `ram_addr=cpu_addr`, `ram_we=cpu_we`, `ram_wdata=cpu_wdata`, then go to WAIT_DATA.
  - Otherwise drive `ram_addr=vid_addr`, `ram_we=0`.
- **WAIT_DATA:** the port goes to video (`vid_addr`, `ram_we=0`). Capture `ram_rdata` into `cpu_rdata` if the access was a read. Go to ACK.
- **ACK:** assert `cpu_ack`. The port goes to video. No CPU grant this cycle. Return to IDLE.
- **Port owner:** combinational mux. `owner_q` records the previous-cycle owner.
  - If `owner_q` is video, `vid_rdata = ram_rdata`, and the value is also loaded into a hold register.
  - Otherwise `vid_rdata` = the hold register.
- **Writes:** `cpu_rdata` is unchanged by write accesses.
- **Reset:** resets state to IDLE, the hold register and `cpu_rdata` to 0, `owner_q` to video, and the wait counter to 0.
  - While in reset: `cpu_ack=0`, `vid_miss=0`, `ram_we=0`, `ram_addr=vid_addr`.
  - Reset mid-access drops the pending ack; the CPU must re-issue. A write already strobed may have landed.
- **Simultaneous requests:** video wins unless the guard forces a CPU slot.
- **CPU arriving in WAIT_DATA/ACK:** the request waits; it is first considered in IDLE.

## Timing
- **CPU latency:** request granted in cycle N → `cpu_ack` and valid `cpu_rdata` in cycle N+2.
  - Minimum request-to-request spacing is 3 cycles.
  - With `vid_req` held low: ack at N+2, next grant possible at N+3.
- **Video latency:** request in cycle N → `vid_rdata` valid in N+1, combinational from `ram_rdata`.
- **Write timing:** `ram_we` is high for exactly one cycle, the grant cycle.
- **Sampling:** all control outputs except `vid_rdata` and the RAM mux are registered.

## Configuration
- **`VRAM_ARB_STARVE_GUARD_EN` defined:**
  - An 8-bit wait counter increments each IDLE cycle with `cpu_req && vid_req && !force`, and clears on CPU grant.
  - `force = (count == STARVE_LIMIT)`.
  - A forced grant while `vid_req=1` sets `vid_miss=1` in the next cycle, and `vid_rdata` repeats the hold register.
- **Macro undefined:**
  - No counter, `force=0`, `vid_miss` tied 0.
  - The CPU can starve indefinitely under continuous `vid_req`.

## Test plan
- Idle video, CPU write 0x5A to 0x0400 then read 0x0400: `ram_we` pulses once at the grant; the read acks 2 cycles after grant with `cpu_rdata=0x5A`.
- `vid_req` continuous to address 0x1000 (preloaded 0xC3): `vid_rdata=0xC3` every cycle from the second cycle on, `vid_miss=0`.
- Guard on, `STARVE_LIMIT=4`, `vid_req` and `cpu_req` both held: CPU granted on the 5th cycle, `vid_miss` pulses one cycle, `vid_rdata` repeats the prior byte, counter clears.
- Guard off, same stimulus for 1000 cycles: `cpu_ack` never asserts and `vid_miss` stays 0; dropping `vid_req` → ack 2 cycles later.
- Assert `rst_n=0` in the WAIT_DATA cycle of a read: no `cpu_ack`, `cpu_rdata=0`, state IDLE; the re-issued read acks normally.
- CPU request raised during the ACK cycle of a prior access: not granted until the following IDLE cycle, i.e. 3-cycle spacing.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, the video fetch path, the CPU bus and the RAM port.
// slave is the arbiter's view; master is the surrounding system's view.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 8
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [XLEN-1:0]       vid_rdata;
  logic                  vid_miss;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [XLEN-1:0]       cpu_wdata;
  logic                  cpu_ack;
  logic [XLEN-1:0]       cpu_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [XLEN-1:0]       ram_wdata;
  logic [XLEN-1:0]       ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_rdata, vid_miss, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_rdata, vid_miss, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has fixed priority, CPU accesses fill idle slots.
// Define VRAM_ARB_STARVE_GUARD_EN to add the CPU starvation guard (forced slot + vid_miss).
module vram_arbiter #(
  parameter int RAM_SIZE     = 8192,
  parameter int ADDR_WIDTH   = $clog2(RAM_SIZE),
  parameter int XLEN         = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("vram_arbiter: STARVE_LIMIT must be within 1..255");
  end
  if (RAM_SIZE > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
    $error("vram_arbiter: ADDR_WIDTH too small for RAM_SIZE");
  end

  typedef enum logic [1:0] {IDLE, WAIT_DATA, ACK} state_e;

  state_e          state_q, state_d;
  logic            owner_cpu_q, owner_cpu_d;
  logic            rd_access_q, rd_access_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] cpu_rdata_q, cpu_rdata_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            vid_miss_q, vid_miss_d;
  logic            grant;
  logic            force_grant;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign force_grant = (wait_cnt_q == 8'(STARVE_LIMIT));

  // Counts only cycles where the CPU actually lost to video; stops at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant) begin
      wait_cnt_d = '0;
    end else if (state_q == IDLE && bus.cpu_req && bus.vid_req && !force_grant) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  assign force_grant = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_cpu_d  = 1'b0;
    rd_access_d  = rd_access_q;
    hold_d       = hold_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = 1'b0;
    vid_miss_d   = 1'b0;
    grant        = 1'b0;
    bus.ram_addr = bus.vid_addr;
    bus.ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gates the grant so the RAM port stays with video throughout reset.
        if (rst_n && bus.cpu_req && (!bus.vid_req || force_grant)) begin
          grant        = 1'b1;
          owner_cpu_d  = 1'b1;
          rd_access_d  = !bus.cpu_we;
          vid_miss_d   = force_grant && bus.vid_req;
          bus.ram_addr = bus.cpu_addr;
          bus.ram_we   = bus.cpu_we;
          state_d      = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (rd_access_q) cpu_rdata_d = bus.ram_rdata;
        cpu_ack_d = 1'b1;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!owner_cpu_q) hold_d = bus.ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_cpu_q <= 1'b0;
      rd_access_q <= 1'b0;
      hold_q      <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_cpu_q <= owner_cpu_d;
      rd_access_q <= rd_access_d;
      hold_q      <= hold_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_miss_q  <= vid_miss_d;
    end
  end

  // A stolen slot leaves ram_rdata holding CPU data, so video sees the last byte it fetched.
  assign bus.vid_rdata = owner_cpu_q ? hold_q : bus.ram_rdata;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q && rst_n;
  assign bus.vid_miss  = vid_miss_q && rst_n;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, corner sequences, random traffic
// against a cycle-indexed reference model with its own memory image.
module tb_vram_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [12:0] A400  = 13'h0400;
  localparam logic [12:0] A401  = 13'h0401;
  localparam logic [12:0] A1000 = 13'h1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(13), .XLEN(8)) bus ();

  vram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index of the last CPU grant, a memory image (entry absent = unknown),
  // and the byte the RAM presents this cycle.
  logic [7:0] mmem [int];
  int         cyc = 0;
  int         g_cyc = -100;
  logic       g_we = 1'b0;
  logic [7:0] g_rd = 8'h00;
  bit         g_rd_ok = 1'b0;
  logic [7:0] m_crd = 8'h00;
  bit         m_crd_ok = 1'b1;
  logic [7:0] m_hold = 8'h00;
  bit         m_hold_ok = 1'b1;
  logic [7:0] m_rd = 8'h00;
  bit         m_rd_ok = 1'b0;
  bit         m_prev_vid = 1'b1;
  bit         m_miss = 1'b0;
  bit         m_ack = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void look(input logic [12:0] a, output logic [7:0] v, output bit ok);
    if (mmem.exists(int'(a))) begin
      v  = mmem[int'(a)];
      ok = 1'b1;
    end else begin
      v  = 8'h00;
      ok = 1'b0;
    end
  endfunction

  task automatic model_cycle();
    logic [12:0] ea;
    logic        ew, eack, frc, grt, free;
    logic [7:0]  ev;
    bit          evok;
    if (!rst_n) begin
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'(bus.vid_addr));
      chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
      chk("rst_vid_miss", 32'(bus.vid_miss), 32'd0);
      look(bus.vid_addr, m_rd, m_rd_ok);
      g_cyc = -100; m_cnt = 0; m_crd = 8'h00; m_crd_ok = 1'b1;
      m_hold = 8'h00; m_hold_ok = 1'b1; m_prev_vid = 1'b1; m_miss = 1'b0; m_ack = 1'b0;
    end else begin
      free = (cyc - g_cyc) >= 3;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      frc = (m_cnt == STARVE_LIMIT);
`else
      frc = 1'b0;
`endif
      grt  = free && bus.cpu_req && (!bus.vid_req || frc);
      ea   = grt ? bus.cpu_addr : bus.vid_addr;
      ew   = grt && bus.cpu_we;
      eack = (cyc == g_cyc + 2);
      if (eack && !g_we) begin m_crd = g_rd; m_crd_ok = g_rd_ok; end
      if (m_prev_vid) begin ev = m_rd; evok = m_rd_ok; end
      else begin ev = m_hold; evok = m_hold_ok; end
      chk("m_ram_we", 32'(bus.ram_we), 32'(ew));
      chk("m_ram_addr", 32'(bus.ram_addr), 32'(ea));
      chk("m_cpu_ack", 32'(bus.cpu_ack), 32'(eack));
      chk("m_vid_miss", 32'(bus.vid_miss), 32'(m_miss));
      if (ew) chk("m_ram_wdata", 32'(bus.ram_wdata), 32'(bus.cpu_wdata));
      if (m_crd_ok) chk("m_cpu_rdata", 32'(bus.cpu_rdata), 32'(m_crd));
      if (evok) chk("m_vid_rdata", 32'(bus.vid_rdata), 32'(ev));
      m_ack = eack;
      if (m_prev_vid) begin m_hold = m_rd; m_hold_ok = m_rd_ok; end
      look(ea, m_rd, m_rd_ok);
      m_miss = grt && frc && bus.vid_req;
      if (grt) begin
        g_cyc = cyc; g_we = bus.cpu_we; g_rd = m_rd; g_rd_ok = m_rd_ok; m_cnt = 0;
        if (bus.cpu_we) mmem[int'(bus.cpu_addr)] = bus.cpu_wdata;
      end else if (free && bus.cpu_req && bus.vid_req && !frc) begin
        m_cnt++;
      end
      m_prev_vid = !grt;
    end
    cyc++;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vreq, input logic [12:0] vaddr, input logic creq,
                       input logic cwe, input logic [12:0] caddr, input logic [7:0] cwd);
    bus.vid_req = vreq; bus.vid_addr = vaddr;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
  endtask

  typedef struct packed {
    logic        vreq;
    logic [12:0] vaddr;
    logic        creq;
    logic        cwe;
    logic [12:0] caddr;
    logic [7:0]  cwd;
    logic        e_we;
    logic [12:0] e_addr;
    logic        e_ack;
    logic        chk_crd;
    logic [7:0]  e_crd;
    logic        chk_vrd;
    logic [7:0]  e_vrd;
  } vec_t;

  vec_t tv [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // vreq vaddr creq we caddr wdata | ram_we ram_addr ack chk_crd crd chk_vrd vrd
    tv[0]  = '{L, A1000, H, H, A400,  8'h5A, H, A400,  L, L, 8'h00, L, 8'h00};
    tv[1]  = '{L, A1000, H, H, A400,  8'h5A, L, A1000, L, L, 8'h00, L, 8'h00};
    tv[2]  = '{L, A1000, H, H, A400,  8'h5A, L, A1000, H, H, 8'h00, L, 8'h00};
    tv[3]  = '{L, A1000, H, L, A400,  8'h00, L, A400,  L, H, 8'h00, L, 8'h00};
    tv[4]  = '{L, A1000, H, L, A400,  8'h00, L, A1000, L, H, 8'h00, L, 8'h00};
    tv[5]  = '{L, A1000, H, L, A400,  8'h00, L, A1000, H, H, 8'h5A, L, 8'h00};
    tv[6]  = '{L, A1000, H, H, A1000, 8'hC3, H, A1000, L, H, 8'h5A, L, 8'h00};
    tv[7]  = '{L, A1000, H, H, A1000, 8'hC3, L, A1000, L, H, 8'h5A, L, 8'h00};
    tv[8]  = '{L, A1000, H, H, A1000, 8'hC3, L, A1000, H, H, 8'h5A, L, 8'h00};
    tv[9]  = '{H, A1000, L, L, A400,  8'h00, L, A1000, L, H, 8'h5A, L, 8'h00};
    tv[10] = '{H, A1000, L, L, A400,  8'h00, L, A1000, L, H, 8'h5A, H, 8'hC3};
    tv[11] = '{H, A1000, L, L, A400,  8'h00, L, A1000, L, H, 8'h5A, H, 8'hC3};
    tv[12] = '{H, A1000, L, L, A400,  8'h00, L, A1000, L, H, 8'h5A, H, 8'hC3};
    tv[13] = '{L, A1000, H, H, A401,  8'h11, H, A401,  L, H, 8'h5A, H, 8'hC3};
    tv[14] = '{L, A1000, H, H, A401,  8'h11, L, A1000, L, H, 8'h5A, H, 8'hC3};
    tv[15] = '{L, A1000, H, L, A401,  8'h00, L, A1000, H, H, 8'h5A, H, 8'hC3};
    tv[16] = '{L, A1000, H, L, A401,  8'h00, L, A401,  L, H, 8'h5A, L, 8'h00};
    tv[17] = '{L, A1000, H, L, A401,  8'h00, L, A1000, L, H, 8'h5A, L, 8'h00};
    tv[18] = '{L, A1000, H, L, A401,  8'h00, L, A1000, H, H, 8'h11, L, 8'h00};

    // Reset with a CPU write pending: nothing may reach the RAM.
    rst_n = 1'b0;
    drive(L, 13'h1234, H, H, A400, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      if (i == 2) chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      next();
    end
    rst_n = 1'b1;
    drive(L, A1000, L, L, A400, 8'h00);
    at_neg(); next();

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].vreq, tv[i].vaddr, tv[i].creq, tv[i].cwe, tv[i].caddr, tv[i].cwd);
      at_neg();
      chk($sformatf("tv%0d_ram_we", i), 32'(bus.ram_we), 32'(tv[i].e_we));
      chk($sformatf("tv%0d_ram_addr", i), 32'(bus.ram_addr), 32'(tv[i].e_addr));
      chk($sformatf("tv%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'(tv[i].e_ack));
      chk($sformatf("tv%0d_vid_miss", i), 32'(bus.vid_miss), 32'd0);
      if (tv[i].chk_crd) chk($sformatf("tv%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tv[i].e_crd));
      if (tv[i].chk_vrd) chk($sformatf("tv%0d_vid_rdata", i), 32'(bus.vid_rdata), 32'(tv[i].e_vrd));
      next();
    end
    drive(L, A1000, L, L, A400, 8'h00);
    at_neg(); next();

    // Reset lands in the WAIT_DATA cycle of a read; the held request is granted again afterwards.
    drive(L, A1000, H, L, A400, 8'h00);
    at_neg(); chk("rstmid_grant", 32'(bus.ram_addr), 32'(A400)); next();
    rst_n = 1'b0;
    at_neg(); next();
    rst_n = 1'b1;
    at_neg();
    chk("rstmid_no_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rstmid_rdata_cleared", 32'(bus.cpu_rdata), 32'd0);
    chk("rstmid_regrant", 32'(bus.ram_addr), 32'(A400));
    next();
    at_neg(); chk("rstmid_wait_no_ack", 32'(bus.cpu_ack), 32'd0); next();
    at_neg();
    chk("rstmid_ack", 32'(bus.cpu_ack), 32'd1);
    chk("rstmid_rdata", 32'(bus.cpu_rdata), 32'h5A);
    next();
    drive(L, A1000, L, L, A400, 8'h00);
    at_neg(); next();

    // Video streams continuously while the CPU waits for a read of 0x0401.
    drive(H, A1000, H, L, A401, 8'h00);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 5; i++) begin
        at_neg();
        chk("starve_ram_addr", 32'(bus.ram_addr), (i == 4) ? 32'(A401) : 32'(A1000));
        if (i < 4) chk("starve_vid_rdata", 32'(bus.vid_rdata), 32'hC3);
        next();
      end
      at_neg();
      chk("starve_vid_miss", 32'(bus.vid_miss), 32'd1);
      chk("starve_vid_rdata_held", 32'(bus.vid_rdata), 32'hC3);
      next();
      at_neg();
      chk("starve_ack", 32'(bus.cpu_ack), 32'd1);
      chk("starve_miss_single", 32'(bus.vid_miss), 32'd0);
      chk("starve_rdata", 32'(bus.cpu_rdata), 32'h11);
      next();
    end
    drive(H, A1000, L, L, A401, 8'h00);
    at_neg(); next();
`else
    for (int i = 0; i < 1000; i++) begin
      at_neg();
      chk("starve_no_ack", 32'(bus.cpu_ack), 32'd0);
      chk("starve_no_miss", 32'(bus.vid_miss), 32'd0);
      next();
    end
    bus.vid_req = 1'b0;
    at_neg(); chk("starve_release_grant", 32'(bus.ram_addr), 32'(A401)); next();
    at_neg(); chk("starve_release_wait", 32'(bus.cpu_ack), 32'd0); next();
    at_neg();
    chk("starve_release_ack", 32'(bus.cpu_ack), 32'd1);
    chk("starve_release_rdata", 32'(bus.cpu_rdata), 32'h11);
    next();
    drive(L, A1000, L, L, A401, 8'h00);
    at_neg(); next();
`endif

    // Random traffic over a small address window so reads frequently hit earlier writes.
    begin
      bit active = 1'b0;
      int gap = 0;
      for (int i = 0; i < 800; i++) begin
        bus.vid_req  = 1'($urandom_range(0, 1));
        bus.vid_addr = A400 + 13'($urandom_range(0, 7));
        if (!active) begin
          if (gap > 0) begin
            gap--;
            bus.cpu_req = 1'b0;
          end else begin
            active        = 1'b1;
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = A400 + 13'($urandom_range(0, 7));
            bus.cpu_wdata = 8'($urandom);
          end
        end
        at_neg();
        if (m_ack) begin
          active      = 1'b0;
          gap         = $urandom_range(0, 2);
          bus.cpu_req = 1'b0;
        end
        next();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
